// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline stages.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with reset > flush > stall > load priority.
// A flush inserts a bubble but keeps the PC fields, so later stages still see a sane PC.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   stall,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q.instr    <= BUBBLE_INSTR;
            q.pc       <= '0;
            q.pc_plus4 <= '0;
            q.valid    <= 1'b0;
        end else if (flush) begin
            q.instr <= BUBBLE_INSTR;
            q.valid <= 1'b0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register,
// out-of-range and misaligned-redirect detection, delivered-instruction counter.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = riscv_pkg::RESET_PC,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        misalign_err,
    output logic        oob_err,
    output logic [31:0] fetch_count
);

    localparam logic [XLEN-3:0] IMEM_LIMIT = (XLEN-2)'(IMEM_WORDS);

    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] pc_f_plus4;
    logic            in_range;
    logic            bubble;
    logic            load;
    if_id_t          if_id_next;
    if_id_t          if_id_q;

    assign imem_addr  = pc_f;
    assign pc_f_plus4 = pc_f + 32'd4;
    assign in_range   = pc_f[XLEN-1:2] < IMEM_LIMIT;

    // A redirect squashes the instruction fetched down the wrong path.
    assign bubble = flush_d || redirect;
    assign load   = !bubble && !stall_d;

    always_comb begin
        if_id_next.instr    = in_range ? imem_rd : NOP_INSTR;
        if_id_next.pc       = pc_f;
        if_id_next.pc_plus4 = pc_f_plus4;
        if_id_next.valid    = in_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else if (redirect) begin
            pc_f <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (!stall_f) begin
            pc_f <= pc_f_plus4;
        end
    end

    // Error flags are sticky until reset; the counter tracks only real instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
            oob_err      <= 1'b0;
            fetch_count  <= '0;
        end else begin
            if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
            if (load && !in_range) begin
                oob_err <= 1'b1;
            end
            if (load && in_range) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .flush (bubble),
        .stall (stall_d),
        .d     (if_id_next),
        .q     (if_id_q)
    );

    assign instr_d    = if_id_q.instr;
    assign pc_d       = if_id_q.pc;
    assign pc_plus4_d = if_id_q.pc_plus4;
    assign valid_d    = if_id_q.valid;

endmodule
